// File: rtl/fft_twiddle_pkg.sv
// fft_twiddle_pkg: shared constants for the 4/3 twiddle stages of the N=128 FFT
// UNITY_SHIFT : log2 of unity gain (2^9 = 512)
// CSD_K       : scaled twiddle constant, -363 = CSD sum of the shift list
// CSD_SHIFT   : CSD term shifts, CSD_NEG bit k set when term k is subtracted
// phase_t     : 4-phase twiddle schedule 1, +j, 1, conj(W)
package fft_twiddle_pkg;
    localparam int UNITY_SHIFT = 9;
    localparam int CSD_K = -363;
    localparam int CSD_TERMS = 5;
    localparam int CSD_SHIFT [CSD_TERMS] = '{9, 7, 4, 2, 0};
    localparam logic [CSD_TERMS-1:0] CSD_NEG = 5'b00001;
    typedef enum logic [1:0] {
        PH_ONE0 = 2'd0,
        PH_PJ   = 2'd1,
        PH_ONE2 = 2'd2,
        PH_W    = 2'd3
    } phase_t;
endpackage

// File: rtl/contador_fase.sv
// contador_fase: 2-bit twiddle phase counter with enable and sync load
// clk  : rising-edge clock
// rst  : asynchronous active-low reset, phase returns to 0
// en   : a sample is consumed this cycle, counter advances
// sync : with en, forces the current sample to phase 0
// fase : phase applied to the current sample
module contador_fase
    import fft_twiddle_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   sync,
    output phase_t fase
);
    phase_t cnt;
    assign fase = sync ? PH_ONE0 : cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= PH_ONE0;
        else if (en)
            cnt <= phase_t'(fase + 2'd1);
endmodule

// File: rtl/multip_csd_conj_4_3.sv
// multip_csd_conj_4_3: pipelined conjugate 4/3 twiddle multiplier (IFFT direction)
// clk       : rising-edge clock
// rst       : asynchronous active-low reset
// muestra   : {real, imag} input sample, NBITS each, two's complement
// in_valid  : muestra valid this cycle
// sync      : with in_valid, processes this sample as phase 0
// result    : {real, imag} product, NBITS_out each, 2-cycle latency
// out_valid : result valid this cycle
module multip_csd_conj_4_3
    import fft_twiddle_pkg::*;
#(
    parameter int NBITS      = 12,
    parameter int NBITScoeff = 11,
    parameter int NBITS_out  = NBITS + NBITScoeff + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS-1:0]     muestra,
    input  logic                   in_valid,
    input  logic                   sync,
    output logic [2*NBITS_out-1:0] result,
    output logic                   out_valid
);
    localparam int U_SH = NBITScoeff - 2;
    phase_t fase, ph1;
    logic v1;
    logic signed [NBITS-1:0] mr_in, mi_in, mr1, mi1;
    logic signed [NBITS:0] s_in, d_in, s1, d1;
    logic signed [NBITS_out-1:0] mr_x, mi_x, s_x, d_x, csd_s, csd_d, r_sel, i_sel;
    contador_fase u_fase (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .sync (sync),
        .fase (fase)
    );
    assign mr_in = muestra[2*NBITS-1:NBITS];
    assign mi_in = muestra[NBITS-1:0];
    // pre-add for conj(W) = K(1-j): real uses mr+mi, imag uses mi-mr
    assign s_in = (NBITS+1)'(mr_in) + (NBITS+1)'(mi_in);
    assign d_in = (NBITS+1)'(mi_in) - (NBITS+1)'(mr_in);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v1  <= 1'b0;
            ph1 <= PH_ONE0;
            mr1 <= '0;
            mi1 <= '0;
            s1  <= '0;
            d1  <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                ph1 <= fase;
                mr1 <= mr_in;
                mi1 <= mi_in;
                s1  <= s_in;
                d1  <= d_in;
            end
        end
    // operands widened before any negation so -2^(NBITS-1) stays exact
    assign mr_x = NBITS_out'(mr1);
    assign mi_x = NBITS_out'(mi1);
    assign s_x  = NBITS_out'(s1);
    assign d_x  = NBITS_out'(d1);
    always_comb begin
        csd_s = '0;
        csd_d = '0;
        for (int k = 0; k < CSD_TERMS; k++) begin
            csd_s = CSD_NEG[k] ? csd_s - (s_x <<< CSD_SHIFT[k]) : csd_s + (s_x <<< CSD_SHIFT[k]);
            csd_d = CSD_NEG[k] ? csd_d - (d_x <<< CSD_SHIFT[k]) : csd_d + (d_x <<< CSD_SHIFT[k]);
        end
    end
    assign r_sel = (ph1 == PH_PJ) ? -(mi_x <<< U_SH) : (ph1 == PH_W) ? csd_s : mr_x <<< U_SH;
    assign i_sel = (ph1 == PH_PJ) ? mr_x <<< U_SH : (ph1 == PH_W) ? csd_d : mi_x <<< U_SH;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= v1;
            if (v1)
                result <= {r_sel, i_sel};
        end
endmodule

// File: tb/tb_multip_csd_conj_4_3.sv
// tb_multip_csd_conj_4_3: directed table, corner sequences and random stream against a golden model
module tb_multip_csd_conj_4_3;
    import fft_twiddle_pkg::*;
    localparam int NB = 12;
    localparam int NO = 24;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2*NB-1:0] muestra = '0;
    logic in_valid = 1'b0;
    logic sync = 1'b0;
    logic [2*NO-1:0] result;
    logic out_valid;
    int n_chk = 0;
    int n_fail = 0;
    int mph = 0;
    logic pv = 1'b0;
    logic [2*NO-1:0] last_res = '0;
    logic [2*NO-1:0] q[$];
    typedef struct {
        logic signed [NB-1:0] mr;
        logic signed [NB-1:0] mi;
        logic signed [NO-1:0] er;
        logic signed [NO-1:0] ei;
    } vec_t;
    vec_t tbl[12];

    multip_csd_conj_4_3 dut (
        .clk       (clk),
        .rst       (rst),
        .muestra   (muestra),
        .in_valid  (in_valid),
        .sync      (sync),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2*NO-1:0] act, input logic [2*NO-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*NO-1:0] model(input int r, input int i, input int ph);
        int u, pr, pi;
        u = 1 << UNITY_SHIFT;
        pr = (ph == 1) ? -i * u : (ph == 3) ? CSD_K * (r + i) : r * u;
        pi = (ph == 1) ? r * u : (ph == 3) ? CSD_K * (i - r) : i * u;
        return {pr[NO-1:0], pi[NO-1:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        sync = 1'b0;
        step();
        step();
        rst = 1'b1;
        mph = 0;
        pv = 1'b0;
        last_res = '0;
        q.delete();
    endtask

    task automatic send(input string name, input int r, input int i, input logic sy, input int er, input int ei);
        in_valid = 1'b1;
        sync = sy;
        muestra = {r[NB-1:0], i[NB-1:0]};
        step();
        in_valid = 1'b0;
        sync = 1'b0;
        step();
        chk({name, "_valid"}, {47'd0, out_valid}, 48'd1);
        chk(name, result, {er[NO-1:0], ei[NO-1:0]});
        step();
    endtask

    // one scoreboarded cycle: output seen now belongs to the input of the previous call
    task automatic cyc(input logic v, input logic sy, input int r, input int i);
        int ph;
        in_valid = v;
        sync = sy;
        muestra = {r[NB-1:0], i[NB-1:0]};
        if (v) begin
            ph = sy ? 0 : mph;
            q.push_back(model(r, i, ph));
            mph = (ph + 1) % 4;
        end
        step();
        chk("sb_valid", {47'd0, out_valid}, {47'd0, pv});
        if (out_valid && q.size() > 0) begin
            last_res = q.pop_front();
            chk("sb_result", result, last_res);
        end else if (!out_valid) begin
            chk("sb_hold", result, last_res);
        end
        pv = v;
    endtask

    initial begin
        tbl[0]  = '{100, -50, 51200, -25600};
        tbl[1]  = '{100, -50, 25600, 51200};
        tbl[2]  = '{100, -50, 51200, -25600};
        tbl[3]  = '{100, -50, -18150, 54450};
        tbl[4]  = '{-2048, -2048, -1048576, -1048576};
        tbl[5]  = '{0, -2048, 1048576, 0};
        tbl[6]  = '{7, 3, 3584, 1536};
        tbl[7]  = '{-2048, -2048, 1486848, 0};
        tbl[8]  = '{2047, -2048, 1048064, -1048576};
        tbl[9]  = '{-1, 5, -2560, -512};
        tbl[10] = '{0, 0, 0, 0};
        tbl[11] = '{2047, -2048, 363, 1486485};

        step();
        chk("reset_valid", {47'd0, out_valid}, 48'd0);
        chk("reset_result", result, 48'd0);
        do_reset();
        chk("release_valid", {47'd0, out_valid}, 48'd0);
        chk("release_result", result, 48'd0);

        for (int k = 0; k <= 12; k++) begin
            in_valid = (k < 12);
            if (k < 12) muestra = {tbl[k].mr, tbl[k].mi};
            step();
            if (k >= 1) begin
                chk($sformatf("tbl%0d_valid", k - 1), {47'd0, out_valid}, 48'd1);
                chk($sformatf("tbl%0d", k - 1), result, {tbl[k-1].er, tbl[k-1].ei});
            end
        end
        in_valid = 1'b0;
        step();
        step();
        chk("tbl_drain_valid", {47'd0, out_valid}, 48'd0);
        chk("tbl_drain_hold", result, {tbl[11].er, tbl[11].ei});

        do_reset();
        send("sync_p0", 10, 20, 1'b0, 5120, 10240);
        send("sync_p1", 10, 20, 1'b0, -10240, 5120);
        send("sync_forced_p0", 10, 20, 1'b1, 5120, 10240);
        send("sync_next_p1", 10, 20, 1'b0, -10240, 5120);
        sync = 1'b1;
        step();
        sync = 1'b0;
        send("sync_idle_p2", 10, 20, 1'b0, 5120, 10240);
        send("sync_idle_p3", 10, 20, 1'b0, -10890, -3630);
        send("sync_on_p0", 10, 20, 1'b1, 5120, 10240);

        in_valid = 1'b1;
        muestra = {12'sd100, -12'sd50};
        step();
        muestra = {12'sd1, 12'sd1};
        step();
        in_valid = 1'b0;
        chk("inflight_pre_valid", {47'd0, out_valid}, 48'd1);
        #3 rst = 1'b0;
        #1;
        chk("inflight_rst_valid", {47'd0, out_valid}, 48'd0);
        chk("inflight_rst_result", result, 48'd0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_valid0", {47'd0, out_valid}, 48'd0);
        step();
        chk("post_rst_valid1", {47'd0, out_valid}, 48'd0);
        chk("post_rst_result", result, 48'd0);
        send("post_rst_p0", 100, -50, 1'b0, 51200, -25600);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 300 - 97 * k, -40 + 211 * k);
            for (int g = 0; g <= k % 3; g++) cyc(1'b0, 1'b0, 0, 0);
        end
        for (int k = 0; k < 1000; k++)
            cyc(1'b1, ($urandom_range(0, 15) == 0), $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        chk("sb_drained", 48'(q.size()), 48'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
